// File: rtl/audio_pkg.sv
// Shared audio types: sample width, stereo frame payload, tx state and channel enums.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } frame_t;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} tx_state_t;

  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} chan_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous DEPTH x W frame FIFO with show-ahead read; shared by playback and capture paths.
module sample_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S / left-justified DAC serialiser; codec is BCLK/LRCK master, frames buffered in a small FIFO.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned N         = SAMPLE_W,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned I2S_DELAY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bclk,
  input  logic         daclrck,
  input  logic [N-1:0] sample_left,
  input  logic [N-1:0] sample_right,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         dacdat,
  output logic         underrun
);

  localparam int unsigned FW = 2 * N;
  localparam int unsigned CW = $clog2(N);

  logic bclk_s1, bclk_s2, bclk_prev;
  logic lrck_s1, lrck_s2, lrck_last;
  logic bfall, slot_start;
  chan_t new_chan;

  logic          fifo_full, fifo_empty, pop;
  logic [FW-1:0] fifo_rdata;

  tx_state_t     state, state_n;
  logic [N-1:0]  shreg, shreg_n;
  logic [N-1:0]  hold_r, hold_r_n;
  logic [N-1:0]  word;
  logic [CW-1:0] cnt, cnt_n;
  logic          dacdat_n, underrun_n;

  // Two-flop synchronisers; lrck_last remembers LRCK as seen at the previous bfall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_prev <= 1'b0;
      lrck_s1   <= 1'b0;
      lrck_s2   <= 1'b0;
      lrck_last <= 1'b0;
    end else begin
      bclk_s1   <= bclk;
      bclk_s2   <= bclk_s1;
      bclk_prev <= bclk_s2;
      lrck_s1   <= daclrck;
      lrck_s2   <= lrck_s1;
      if (bfall) lrck_last <= lrck_s2;
    end
  end

  assign bfall      = bclk_prev && !bclk_s2;
  assign slot_start = bfall && (lrck_s2 != lrck_last);
  assign new_chan   = chan_t'(lrck_s2);

  sample_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (sample_valid),
    .wdata ({sample_left, sample_right}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sample_ready = !fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      hold_r   <= '0;
      cnt      <= '0;
      dacdat   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      hold_r   <= hold_r_n;
      cnt      <= cnt_n;
      dacdat   <= dacdat_n;
      underrun <= underrun_n;
    end
  end

  // Slot starts take priority and truncate whatever word is in flight.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    hold_r_n   = hold_r;
    cnt_n      = cnt;
    dacdat_n   = dacdat;
    underrun_n = 1'b0;
    pop        = 1'b0;
    word       = '0;

    if (slot_start && (state != IDLE || new_chan == LEFT)) begin
      if (new_chan == LEFT) begin
        pop        = !fifo_empty;
        underrun_n = fifo_empty;
        word       = fifo_empty ? '0 : fifo_rdata[FW-1:N];
        hold_r_n   = fifo_empty ? '0 : fifo_rdata[N-1:0];
      end else begin
        word = hold_r;
      end
      if (I2S_DELAY != 0) begin
        state_n  = DELAY;
        shreg_n  = word;
        dacdat_n = 1'b0;
      end else begin
        state_n  = SHIFT;
        dacdat_n = word[N-1];
        shreg_n  = word << 1;
        cnt_n    = CW'(N - 1);
      end
    end else if (bfall) begin
      case (state)
        DELAY: begin
          state_n  = SHIFT;
          dacdat_n = shreg[N-1];
          shreg_n  = shreg << 1;
          cnt_n    = CW'(N - 1);
        end
        SHIFT: begin
          if (cnt == '0) begin
            state_n  = PAD;
            dacdat_n = 1'b0;
          end else begin
            dacdat_n = shreg[N-1];
            shreg_n  = shreg << 1;
            cnt_n    = cnt - CW'(1);
          end
        end
        default: dacdat_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: I2S and left-justified instances share one stimulus stream.
module tb_i2s_dac_tx;
  import audio_pkg::*;

  localparam int unsigned N     = SAMPLE_W;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         bclk;
  logic         daclrck;
  logic [N-1:0] sample_left;
  logic [N-1:0] sample_right;
  logic         sample_valid;
  logic         ready_i2s, ready_lj;
  logic         dat_i2s, dat_lj;
  logic         urun_i2s, urun_lj;

  int total = 0;
  int bad   = 0;
  int ucnt_i2s = 0;
  int ucnt_lj  = 0;

  frame_t bp [6] = '{32'h1111_EEEE, 32'h2222_DDDD, 32'h3333_CCCC,
                     32'h4444_BBBB, 32'h5555_AAAA, 32'h6666_9999};
  frame_t sf [2] = '{32'hC3A5_5A3C, 32'h8421_1248};

  always #5 clk = ~clk;

  i2s_dac_tx #(.N(N), .DEPTH(DEPTH), .I2S_DELAY(1)) dut_i2s (
    .clk(clk), .reset(reset), .bclk(bclk), .daclrck(daclrck),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready_i2s),
    .dacdat(dat_i2s), .underrun(urun_i2s));

  i2s_dac_tx #(.N(N), .DEPTH(DEPTH), .I2S_DELAY(0)) dut_lj (
    .clk(clk), .reset(reset), .bclk(bclk), .daclrck(daclrck),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready_lj),
    .dacdat(dat_lj), .underrun(urun_lj));

  // Count clk cycles with underrun high, sampled mid-cycle.
  always @(negedge clk) begin
    if (urun_i2s === 1'b1) ucnt_i2s++;
    if (urun_lj === 1'b1) ucnt_lj++;
  end

  // Reference slot: dly zero bits, then the word MSB first, then zeros; first bit lands in the MSB.
  function automatic logic [31:0] exp_slot(input logic [N-1:0] w, input int nb, input int dly);
    logic [31:0] v;
    int i;
    v = '0;
    for (int k = 0; k < nb; k++) begin
      i = k - dly;
      v = {v[30:0], (i >= 0 && i < int'(N)) ? w[N-1-i] : 1'b0};
    end
    return v;
  endfunction

  // One BCLK period: LRCK changes with the falling edge; data is captured like the codec, at the rise.
  task automatic bit_clk(input logic lr, output logic d1, output logic d0);
    daclrck = lr;
    bclk    = 1'b0;
    #80;
    bclk = 1'b1;
    #1;
    d1 = dat_i2s;
    d0 = dat_lj;
    #79;
  endtask

  task automatic run_slot(input logic lr, input int nb, output logic [31:0] c1, output logic [31:0] c0);
    logic d1, d0;
    c1 = '0;
    c0 = '0;
    for (int k = 0; k < nb; k++) begin
      bit_clk(lr, d1, d0);
      c1 = {c1[30:0], d1};
      c0 = {c0[30:0], d0};
    end
  endtask

  task automatic push_frame(input logic [N-1:0] l, input logic [N-1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (ready_i2s !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready_i2s !== 1'b1) begin
      total++; bad++;
      $display("FAIL push_wait: ready=%b after %0d cycles, need 1", ready_i2s, n);
    end
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    bclk         = 1'b1;
    daclrck      = 1'b1;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({dat_i2s, dat_lj, urun_i2s, urun_lj} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: dat/urun=%b, need 0000", {dat_i2s, dat_lj, urun_i2s, urun_lj});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({ready_i2s, ready_lj} !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready: ready=%b, need 11", {ready_i2s, ready_lj});
    end
  endtask

  task automatic test_basic_i2s;
    logic [31:0] c1, c0;
    push_frame(16'h8001, 16'h7FFE);
    run_slot(1'b1, 32, c1, c0);
    total++;
    if ({c1, c0} !== 64'h0) begin
      bad++;
      $display("FAIL idle_right: i2s=%h lj=%h, need 0", c1, c0);
    end
    run_slot(1'b0, 32, c1, c0);
    total++;
    if (c1 !== 32'h4000_8000 || c0 !== 32'h8001_0000) begin
      bad++;
      $display("FAIL basic_left: i2s=%h lj=%h, need 40008000 80010000", c1, c0);
    end
    run_slot(1'b1, 32, c1, c0);
    total++;
    if (c1 !== 32'h3FFF_0000 || c0 !== 32'h7FFE_0000) begin
      bad++;
      $display("FAIL basic_right: i2s=%h lj=%h, need 3fff0000 7ffe0000", c1, c0);
    end
    total++;
    if (ucnt_i2s !== 0 || ucnt_lj !== 0) begin
      bad++;
      $display("FAIL basic_no_underrun: cycles i2s=%0d lj=%0d, need 0", ucnt_i2s, ucnt_lj);
    end
  endtask

  task automatic test_left_justified;
    logic [31:0] c1, c0;
    push_frame(16'hA5C3, 16'h0F0F);
    run_slot(1'b0, 32, c1, c0);
    total++;
    if (c0 !== 32'hA5C3_0000 || c1 !== 32'h52E1_8000) begin
      bad++;
      $display("FAIL lj_left: lj=%h i2s=%h, need a5c30000 52e18000", c0, c1);
    end
    run_slot(1'b1, 32, c1, c0);
    total++;
    if (c0 !== 32'h0F0F_0000 || c1 !== 32'h0787_8000) begin
      bad++;
      $display("FAIL lj_right: lj=%h i2s=%h, need 0f0f0000 07878000", c0, c1);
    end
  endtask

  task automatic test_underrun;
    logic [31:0] c1, c0;
    int u1, u0;
    u1 = ucnt_i2s;
    u0 = ucnt_lj;
    run_slot(1'b0, 32, c1, c0);
    total++;
    if ({c1, c0} !== 64'h0) begin
      bad++;
      $display("FAIL underrun_left: i2s=%h lj=%h, need 0", c1, c0);
    end
    total++;
    if (ucnt_i2s - u1 !== 1 || ucnt_lj - u0 !== 1) begin
      bad++;
      $display("FAIL underrun_pulse: cycles i2s=%0d lj=%0d, need 1", ucnt_i2s - u1, ucnt_lj - u0);
    end
    run_slot(1'b1, 32, c1, c0);
    total++;
    if ({c1, c0} !== 64'h0) begin
      bad++;
      $display("FAIL underrun_right: i2s=%h lj=%h, need 0", c1, c0);
    end
    push_frame(16'h1234, 16'h5678);
    run_slot(1'b0, 32, c1, c0);
    total++;
    if (c1 !== 32'h091A_0000 || c0 !== 32'h1234_0000) begin
      bad++;
      $display("FAIL recover_left: i2s=%h lj=%h, need 091a0000 12340000", c1, c0);
    end
    run_slot(1'b1, 32, c1, c0);
    total++;
    if (c1 !== 32'h2B3C_0000 || c0 !== 32'h5678_0000) begin
      bad++;
      $display("FAIL recover_right: i2s=%h lj=%h, need 2b3c0000 56780000", c1, c0);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] c1, c0;
    logic        rdy, exp_rdy;
    int          idx, u1;
    idx = 0;
    u1  = ucnt_i2s;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      {sample_left, sample_right} = bp[idx];
      sample_valid = 1'b1;
      rdy     = ready_i2s;
      exp_rdy = (idx < int'(DEPTH));
      total++;
      if (rdy !== exp_rdy) begin
        bad++;
        $display("FAIL bp_ready cycle %0d: ready=%b, need %b", c, rdy, exp_rdy);
      end
      @(posedge clk);
      if (rdy === 1'b1 && idx < 5) idx++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    total++;
    if (idx !== int'(DEPTH)) begin
      bad++;
      $display("FAIL bp_accepts: accepted=%0d, need %0d", idx, DEPTH);
    end
    for (int f = 0; f < 6; f++) begin
      if (f == 4) begin
        push_frame(bp[4].l, bp[4].r);
        push_frame(bp[5].l, bp[5].r);
      end
      run_slot(1'b0, 32, c1, c0);
      total++;
      if (c1 !== exp_slot(bp[f].l, 32, 1) || c0 !== exp_slot(bp[f].l, 32, 0)) begin
        bad++;
        $display("FAIL bp_left frame %0d: i2s=%h lj=%h, need %h %h", f, c1, c0,
                 exp_slot(bp[f].l, 32, 1), exp_slot(bp[f].l, 32, 0));
      end
      run_slot(1'b1, 32, c1, c0);
      total++;
      if (c1 !== exp_slot(bp[f].r, 32, 1) || c0 !== exp_slot(bp[f].r, 32, 0)) begin
        bad++;
        $display("FAIL bp_right frame %0d: i2s=%h lj=%h, need %h %h", f, c1, c0,
                 exp_slot(bp[f].r, 32, 1), exp_slot(bp[f].r, 32, 0));
      end
    end
    total++;
    if (ucnt_i2s !== u1) begin
      bad++;
      $display("FAIL bp_no_underrun: extra cycles=%0d, need 0", ucnt_i2s - u1);
    end
  endtask

  task automatic test_short_frame;
    logic [31:0] c1, c0;
    logic [N-1:0] w;
    push_frame(sf[0].l, sf[0].r);
    push_frame(sf[1].l, sf[1].r);
    for (int s = 0; s < 4; s++) begin
      w = (s % 2 == 0) ? sf[s/2].l : sf[s/2].r;
      run_slot(1'(s % 2), 12, c1, c0);
      total++;
      if (c1 !== exp_slot(w, 12, 1) || c0 !== exp_slot(w, 12, 0)) begin
        bad++;
        $display("FAIL short_slot %0d: i2s=%h lj=%h, need %h %h", s, c1, c0,
                 exp_slot(w, 12, 1), exp_slot(w, 12, 0));
      end
    end
  endtask

  task automatic test_reset_midword;
    logic [31:0] c1, c0;
    logic d1, d0;
    push_frame(16'hFFFF, 16'hFFFF);
    push_frame(16'hBEEF, 16'hCAFE);
    for (int k = 0; k < 8; k++) bit_clk(1'b0, d1, d0);
    total++;
    if (d1 !== 1'b1 || d0 !== 1'b1) begin
      bad++;
      $display("FAIL midword_data: i2s=%b lj=%b, need 1 1", d1, d0);
    end
    reset = 1'b1;
    #1;
    total++;
    if (dat_i2s !== 1'b0 || dat_lj !== 1'b0) begin
      bad++;
      $display("FAIL midword_reset_dat: i2s=%b lj=%b, need 0 0", dat_i2s, dat_lj);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({ready_i2s, ready_lj} !== 2'b11) begin
      bad++;
      $display("FAIL midword_ready: ready=%b, need 11", {ready_i2s, ready_lj});
    end
    push_frame(16'h0BAD, 16'hF00D);
    run_slot(1'b0, 24, c1, c0);
    run_slot(1'b1, 32, c0, c1);
    total++;
    if ({c1, c0} !== 64'h0) begin
      bad++;
      $display("FAIL midword_quiet: i2s=%h lj=%h, need 0", c1, c0);
    end
    run_slot(1'b0, 32, c1, c0);
    total++;
    if (c1 !== exp_slot(16'h0BAD, 32, 1) || c0 !== exp_slot(16'h0BAD, 32, 0)) begin
      bad++;
      $display("FAIL midword_left: i2s=%h lj=%h, need %h %h", c1, c0,
               exp_slot(16'h0BAD, 32, 1), exp_slot(16'h0BAD, 32, 0));
    end
    run_slot(1'b1, 32, c1, c0);
    total++;
    if (c1 !== exp_slot(16'hF00D, 32, 1) || c0 !== exp_slot(16'hF00D, 32, 0)) begin
      bad++;
      $display("FAIL midword_right: i2s=%h lj=%h, need %h %h", c1, c0,
               exp_slot(16'hF00D, 32, 1), exp_slot(16'hF00D, 32, 0));
    end
  endtask

  initial begin
    test_reset();
    test_basic_i2s();
    test_left_justified();
    test_underrun();
    test_backpressure();
    test_short_frame();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
